// File: rtl/hamming_secded_stream.sv
// Streaming Hamming SEC / SEC-DED decoder with a two-stage valid/ready pipeline
// and saturating corrected/uncorrectable word counters.
module hamming_secded_stream #(
  parameter  int unsigned R          = 3,
  parameter  int unsigned EXT_PARITY = 1,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned N          = (2 ** R) - 1,
  localparam int unsigned K          = N - R,
  localparam int unsigned CW         = N + EXT_PARITY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_data,
  output logic             out_err,
  output logic             out_uncorr,
  output logic [R-1:0]     out_loc,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  logic             en;
  logic             s1_valid_q;
  logic [CW-1:0]    s1_code_q;

  logic             out_valid_q;
  logic [K-1:0]     out_data_q;
  logic             out_err_q;
  logic             out_uncorr_q;
  logic [R-1:0]     out_loc_q;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic [R-1:0]     syn;
  logic             par;
  logic [N-1:0]     fixed;
  logic [K-1:0]     dec_data;
  logic             dec_err;
  logic             dec_unc;
  logic [R-1:0]     dec_loc;

  // Both stages advance together whenever the output register is free or drained.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_code_q <= in_code;
    end
  end

  always_comb begin
    syn = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (s1_code_q[i]) syn = syn ^ R'(i + 1);
    end
    par = (EXT_PARITY != 0) ? ^s1_code_q : (syn != '0);

    fixed   = s1_code_q[N-1:0];
    dec_err = 1'b0;
    dec_unc = 1'b0;
    dec_loc = '0;
    if (syn != '0 && par) begin
      fixed   = s1_code_q[N-1:0] ^ (N'(1) << (syn - R'(1)));
      dec_err = 1'b1;
      dec_loc = syn - R'(1);
    end else if (syn == '0 && par) begin
      dec_err = 1'b1;
      dec_loc = R'(N);
    end else if (syn != '0) begin
      dec_unc = 1'b1;
    end

    // Shift data bits in from the top so the lowest data position lands at bit 0.
    dec_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (((i + 1) & i) != 0) dec_data = {fixed[i], dec_data[K-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      out_uncorr_q <= 1'b0;
      out_loc_q    <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= dec_data;
        out_err_q    <= dec_err;
        out_uncorr_q <= dec_unc;
        out_loc_q    <= dec_loc;
      end
    end
  end

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (clr_cnt) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (en && s1_valid_q) begin
      if (dec_err && corr_cnt_q != '1)   corr_cnt_d   = corr_cnt_q + CNT_W'(1);
      if (dec_unc && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign out_uncorr = out_uncorr_q;
  assign out_loc    = out_loc_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_stream.sv
// Bench for hamming_secded_stream: encoder-based brute-force decode model with a
// per-cycle scoreboard on the default instance, plus directed CNT_W=2 and R=4/SEC cases.
module tb_hamming_secded_stream;

  typedef struct {
    logic [63:0] data;
    bit          err;
    bit          unc;
    int          loc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: a word is a codeword iff re-encoding its data bits reproduces it;
  // decode searches for the nearest codeword by trying every single-bit flip.
  function automatic logic [63:0] extract(input int r, input logic [63:0] c);
    int n = (1 << r) - 1;
    int k = 0;
    logic [63:0] d = '0;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (((c >> (p - 1)) & 64'd1) != 0) d = d | (64'd1 << k);
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [63:0] encode(input int r, input int ext, input logic [63:0] d);
    int n = (1 << r) - 1;
    int k = 0;
    logic [63:0] c = '0;
    bit b;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (((d >> k) & 64'd1) != 0) c = c | (64'd1 << (p - 1));
        k++;
      end
    end
    for (int j = 0; j < r; j++) begin
      b = 1'b0;
      for (int p = 1; p <= n; p++) begin
        if ((p & (p - 1)) != 0 && ((p >> j) & 1) != 0 && ((c >> (p - 1)) & 64'd1) != 0) b = ~b;
      end
      if (b) c = c | (64'd1 << ((1 << j) - 1));
    end
    if (ext != 0 && (^c)) c = c | (64'd1 << n);
    return c;
  endfunction

  function automatic void model(input int r, input int ext, input logic [63:0] c, output exp_t e);
    int cw = (1 << r) - 1 + ext;
    logic [63:0] c2;
    bit found = 1'b0;
    e.data = extract(r, c);
    e.err  = 1'b0;
    e.unc  = 1'b0;
    e.loc  = 0;
    if (encode(r, ext, extract(r, c)) != c) begin
      for (int j = 0; j < cw; j++) begin
        c2 = c ^ (64'd1 << j);
        if (!found && encode(r, ext, extract(r, c2)) == c2) begin
          found  = 1'b1;
          e.err  = 1'b1;
          e.loc  = j;
          e.data = extract(r, c2);
        end
      end
      if (!found) e.unc = 1'b1;
    end
  endfunction

  // Instance A: defaults
  logic        rst_n = 1'b0;
  logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
  logic [7:0]  in_code_a = '0;
  logic [3:0]  out_data_a;
  logic        out_err_a, out_unc_a, clr_a = 1'b0;
  logic [2:0]  out_loc_a;
  logic [15:0] corr_a, unc_cnt_a;

  hamming_secded_stream u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_code(in_code_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_err(out_err_a), .out_uncorr(out_unc_a),
    .out_loc(out_loc_a), .clr_cnt(clr_a), .corr_cnt(corr_a), .uncorr_cnt(unc_cnt_a)
  );

  // Instance B: 2-bit counters
  logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
  logic [7:0]  in_code_b = '0;
  logic [3:0]  out_data_b;
  logic        out_err_b, out_unc_b, clr_b = 1'b0;
  logic [2:0]  out_loc_b;
  logic [1:0]  corr_b, unc_cnt_b;

  hamming_secded_stream #(.CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_code(in_code_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_err(out_err_b), .out_uncorr(out_unc_b),
    .out_loc(out_loc_b), .clr_cnt(clr_b), .corr_cnt(corr_b), .uncorr_cnt(unc_cnt_b)
  );

  // Instance C: R=4, SEC only
  logic        rst_c = 1'b0;
  logic        in_valid_c = 1'b0, in_ready_c, out_valid_c, out_ready_c = 1'b1;
  logic [14:0] in_code_c = '0;
  logic [10:0] out_data_c;
  logic        out_err_c, out_unc_c;
  logic [3:0]  out_loc_c;
  logic [15:0] corr_c, unc_cnt_c;

  hamming_secded_stream #(.R(4), .EXT_PARITY(0)) u_c (
    .clk(clk), .rst_n(rst_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_code(in_code_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_data(out_data_c), .out_err(out_err_c), .out_uncorr(out_unc_c),
    .out_loc(out_loc_c), .clr_cnt(1'b0), .corr_cnt(corr_c), .uncorr_cnt(unc_cnt_c)
  );

  // Scoreboard for instance A, evaluated on the falling edge
  exp_t        q[$];
  bit          head_counted = 1'b0;
  bit          clr_prev = 1'b0;
  logic [15:0] m_corr = '0, m_unc = '0;

  always @(negedge clk) begin
    exp_t e, h;
    bit new_head;
    if (!rst_n) begin
      q.delete();
      head_counted = 1'b0;
      clr_prev     = 1'b0;
      m_corr       = '0;
      m_unc        = '0;
    end else begin
      new_head = 1'b0;
      if (out_valid_a) begin
        if (q.size() == 0) begin
          chk("a_spurious_out_valid", 64'd1, 64'd0);
        end else begin
          h = q[0];
          chk("a_data", 64'(out_data_a), h.data);
          chk("a_err",  64'(out_err_a),  64'(h.err));
          chk("a_unc",  64'(out_unc_a),  64'(h.unc));
          chk("a_loc",  64'(out_loc_a),  64'(h.loc));
          new_head = !head_counted;
          head_counted = 1'b1;
        end
      end
      if (clr_prev) begin
        m_corr = '0;
        m_unc  = '0;
      end else if (new_head) begin
        if (h.err && m_corr != 16'hFFFF) m_corr++;
        if (h.unc && m_unc  != 16'hFFFF) m_unc++;
      end
      chk("a_corr_cnt",   64'(corr_a),    64'(m_corr));
      chk("a_uncorr_cnt", 64'(unc_cnt_a), 64'(m_unc));
      clr_prev = clr_a;
      if (out_valid_a && out_ready_a && q.size() > 0) begin
        void'(q.pop_front());
        head_counted = 1'b0;
      end
      if (in_valid_a && in_ready_a) begin
        model(3, 1, 64'(in_code_a), e);
        q.push_back(e);
      end
    end
  end

  task automatic send_a(input logic [7:0] c);
    @(posedge clk); #1;
    in_valid_a = 1'b1;
    in_code_a  = c;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [7:0]  words [4];
    int          idx;
    logic [63:0] cc, c1, c2;
    bit          seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_out_data",  64'(out_data_a),  64'd0);
    chk("rst_out_err",   64'(out_err_a),   64'd0);
    chk("rst_out_unc",   64'(out_unc_a),   64'd0);
    chk("rst_out_loc",   64'(out_loc_a),   64'd0);
    chk("rst_corr_cnt",  64'(corr_a),      64'd0);
    chk("rst_unc_cnt",   64'(unc_cnt_a),   64'd0);
    chk("rst_c_valid",   64'(out_valid_c), 64'd0);
    rst_n = 1'b1;
    rst_c = 1'b1;

    model(3, 1, 64'h45, e);
    chk("model_45_loc",  64'(e.loc), 64'd4);
    chk("model_45_data", e.data,     64'hB);
    model(3, 1, 64'hD5, e);
    chk("model_D5_loc",  64'(e.loc), 64'd7);
    model(3, 1, 64'h56, e);
    chk("model_56_unc",  64'(e.unc), 64'd1);

    send_a(8'h55);
    chk("clean_valid", 64'(out_valid_a), 64'd1);
    chk("clean_data",  64'(out_data_a),  64'hB);
    chk("clean_err",   64'(out_err_a),   64'd0);
    chk("clean_loc",   64'(out_loc_a),   64'd0);
    chk("clean_corr",  64'(corr_a),      64'd0);
    send_a(8'h45);
    chk("single_err",  64'(out_err_a),   64'd1);
    chk("single_loc",  64'(out_loc_a),   64'd4);
    chk("single_data", 64'(out_data_a),  64'hB);
    chk("single_corr", 64'(corr_a),      64'd1);
    send_a(8'hD5);
    chk("par_err",     64'(out_err_a),   64'd1);
    chk("par_loc",     64'(out_loc_a),   64'd7);
    chk("par_data",    64'(out_data_a),  64'hB);
    send_a(8'h56);
    chk("dbl_unc",     64'(out_unc_a),   64'd1);
    chk("dbl_err",     64'(out_err_a),   64'd0);
    chk("dbl_unc_cnt", 64'(unc_cnt_a),   64'd1);

    // Back-to-back words with the consumer stalled for cycles 3-5
    words[0] = 8'h51; words[1] = 8'h55; words[2] = 8'h5C; words[3] = 8'h45;
    idx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready_a = !(cyc >= 3 && cyc <= 5);
      in_valid_a  = (idx < 4);
      in_code_a   = (idx < 4) ? words[idx] : 8'h00;
      @(negedge clk);
      if (cyc >= 3 && cyc <= 5) chk("stall_in_ready", 64'(in_ready_a), 64'd0);
      if (in_valid_a && in_ready_a) idx++;
      @(posedge clk); #1;
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    chk("stall_all_sent", 64'(idx),      64'd4);
    chk("stall_drained",  64'(q.size()), 64'd0);
    chk("stall_corr",     64'(corr_a),   64'd4);
    chk("stall_unc",      64'(unc_cnt_a), 64'd2);

    for (int j = 0; j < 8; j++) begin
      in_valid_a = 1'b1;
      in_code_a  = 8'h55 ^ (8'd1 << j);
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sweep_corr", 64'(corr_a), 64'd12);

    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    chk("clr_corr", 64'(corr_a),    64'd0);
    chk("clr_unc",  64'(unc_cnt_a), 64'd0);

    // Saturation at 3 with 2-bit counters, then clear beating a simultaneous increment
    for (int j = 0; j < 5; j++) begin
      in_valid_b = 1'b1;
      in_code_b  = 8'h45;
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_corr", 64'(corr_b), 64'd3);
    in_valid_b = 1'b1;
    in_code_b  = 8'h45;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    clr_b      = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
    chk("clrwin_corr",  64'(corr_b),      64'd0);
    chk("clrwin_valid", 64'(out_valid_b), 64'd1);
    chk("clrwin_err",   64'(out_err_b),   64'd1);
    @(posedge clk); #1;
    chk("clrwin_corr_after", 64'(corr_b), 64'd0);

    // R=4 SEC-only: single flip at bit 10
    cc = encode(4, 0, 64'h5A3) ^ (64'd1 << 10);
    model(4, 0, cc, e);
    chk("model_r4_loc", 64'(e.loc), 64'd10);
    in_valid_c = 1'b1;
    in_code_c  = cc[14:0];
    @(posedge clk); #1;
    in_valid_c = 1'b0;
    @(posedge clk); #1;
    chk("r4_valid", 64'(out_valid_c), 64'd1);
    chk("r4_loc",   64'(out_loc_c),   64'd10);
    chk("r4_data",  64'(out_data_c),  64'h5A3);
    chk("r4_err",   64'(out_err_c),   64'd1);
    chk("r4_unc",   64'(out_unc_c),   64'd0);

    // Reset with two words in flight
    c1 = encode(4, 0, 64'h123);
    c2 = encode(4, 0, 64'h456);
    @(posedge clk); #1;
    in_valid_c = 1'b1;
    in_code_c  = c1[14:0];
    @(posedge clk); #1;
    in_code_c  = c2[14:0];
    @(posedge clk); #1;
    in_valid_c = 1'b0;
    chk("inflight_valid", 64'(out_valid_c), 64'd1);
    rst_c = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid_c), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_c = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (out_valid_c) seen = 1'b1;
    end
    chk("rst_no_output", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_secded_stream.md
Name: hamming_secded_stream

Overview:
- Parametrised streaming Hamming decoder: accepts one codeword per cycle over valid/ready, corrects single-bit errors, detects double-bit errors when the extended parity bit is present.
- Outputs corrected data, error flags, error location and saturating error statistics.
- Sits between the USB receive datapath and downstream consumers, succeeding the fixed 7-bit syndrome-only checker.

Parameters:
- R, 3, parity bits; N = 2^R-1 Hamming length, K = N-R data bits; legal 3..6.
- EXT_PARITY, 1, 1 = extra overall-parity MSB (SEC-DED); 0 = SEC only.
- CNT_W, 16, width of error counters.
- Derived: CW = N+EXT_PARITY.

Ports:
- clk  in  1  clock, all flops rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept.
- in_code  in  CW  codeword; bit i = Hamming position i+1; bit N = overall parity when EXT_PARITY=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  K  corrected data.
- out_err  out  1  single error corrected.
- out_uncorr  out  1  uncorrectable (double) error.
- out_loc  out  R  bit index of corrected error.
- clr_cnt  in  1  synchronous counter clear.
- corr_cnt  out  CNT_W  corrected-word count.
- uncorr_cnt  out  CNT_W  uncorrectable-word count.

Behaviour:
- Reset (async assert, sync-deassert assumed upstream): all state and outputs 0: out_valid, out_data, out_err, out_uncorr, out_loc, both counters, stage-1 valid/data.
- Pipeline: 2 register stages.
  - Stage 1 latches in_code.
  - Stage 2 computes syndrome/correction and registers outputs.
  - Latency: 2 cycles from in_valid&&in_ready to out_valid, with no stall.
- Stall: en = !out_valid || out_ready; in_ready = en.
  - When en=0, both stages hold.
  - in_code is ignored when in_ready=0.
  - Bubbles propagate: stage-1 valid=0 loads out_valid=0 when en=1.
  - Throughput: 1 word/cycle.
  - out_* are stable while out_valid && !out_ready.
- Syndrome s (R bits) = XOR of (i+1) over all set bits i < N.
- Overall parity p = XOR of all CW bits (EXT_PARITY=1); p is treated as equal to (s!=0) when EXT_PARITY=0.
- Decode:
  - s=0, p=0: clean; err=0, uncorr=0, loc=0.
  - s!=0, p=1: flip bit s-1; err=1, loc=s-1.
  - s=0, p=1 (EXT only): overall-parity bit in error; data unchanged; err=1, loc=N.
  - s!=0, p=0 (EXT only): double error; uncorr=1, err=0, loc=0; data passed uncorrected.
- Data extraction: bits at non-power-of-two positions (3,5,6,7,9,...), ascending, packed to out_data LSB-first.
- Counters:
  - Increment on stage-2 load of a valid word with err=1 (corr_cnt) or uncorr=1 (uncorr_cnt).
  - Saturate at 2^CNT_W-1, no wrap.
  - clr_cnt zeroes both next cycle and wins over a simultaneous increment.
  - Counters do not advance while stalled (the held word counts once).
- Reset mid-stream: in-flight words are discarded; no output is produced for them.

Test Plan:
- Defaults (R=3, EXT=1, CW=8): in_code=8'h55 -> 2 cycles later out_valid=1, out_data=4'b1011, err=0, uncorr=0, loc=0; counters unchanged.
- in_code=8'h45 (bit 4 flipped) -> out_data=4'b1011, err=1, loc=4, corr_cnt=1.
- in_code=8'hD5 (parity bit flipped) -> out_data=4'b1011, err=1, loc=7; in_code=8'h56 (bits 0,1 flipped) -> uncorr=1, err=0, uncorr_cnt=1.
- Back-to-back 4 words with out_ready=0 for cycles 3-5 -> in_ready=0 during the stall, outputs held stable, all 4 words emitted in order with no loss or duplication, each counted once.
- CNT_W=2, five consecutive correctable words -> corr_cnt stops at 3; clr_cnt pulsed on the same cycle as a sixth error -> corr_cnt=0.
- R=4, EXT=0: 15-bit codeword with a single flip at bit 10 -> loc=10, data corrected; rst_n asserted with 2 words in flight -> out_valid=0 immediately, and no output after release.
